shift_step_register: RTL and testbench

Parametrised successor to the plain enable/clear storage register: a WIDTH-bit register that, besides loading, runs an autonomous sequence of STEPS right-shifts of SHIFT bits each (arithmetic or logical), with a built-in step counter and busy/done handshake. It is the product/remainder register for the iterative multdiv datapath: for example, the 66-bit radix-4 Booth product register shifting 2 bits for 16 steps. A controller can run it directly without an external cycle counter.

---
 rtl/multdiv_pkg.sv | 14 +
 rtl/dffe_ref.sv | 23 ++
 rtl/step_counter.sv | 29 ++
 rtl/shift_step_register.sv | 144 ++++++++++++++
 tb/tb_shift_step_register.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide datapath:
// register sequencing states and shift-mode encodings.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_LOGICAL = 1'b0;
    localparam logic MODE_ARITH   = 1'b1;

endpackage

// File: rtl/dffe_ref.sv
// Reference storage cell: W-bit flop with enable and asynchronous active-low reset to zero.
module dffe_ref #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Enabled capture with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/step_counter.sv
// Saturating step counter with synchronous clear; terminal is high once STEPS steps are counted.
module step_counter #(
    parameter int STEPS = 16,
    parameter int CW    = $clog2(STEPS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    assign terminal = (count == CW'(STEPS));

    // Count enabled steps, holding at STEPS instead of wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/shift_step_register.sv
// Load/shift register running STEPS right-shifts of SHIFT bits per run, with
// its own step counter and busy/done handshake (multdiv product/remainder register).
module shift_step_register
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 66,
    parameter int SHIFT = 2,
    parameter int STEPS = 16,
    localparam int CW   = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             writeEnable,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    state_t           stateR;
    logic             busyR;
    logic             doneR;
    logic             modeR;
    logic [WIDTH-1:0] dataR;
    logic [WIDTH-1:0] dataNextS;
    logic [WIDTH-1:0] shiftedS;
    logic [CW-1:0]    countS;
    logic             terminalS;
    logic             idleOrDoneS;
    logic             runStartS;
    logic             loadS;
    logic             shiftS;
    logic             lastStepS;
    logic             dataEnS;

    assign idleOrDoneS = (stateR != RUN);
    assign runStartS   = idleOrDoneS && !clear && start;
    assign loadS       = idleOrDoneS && !clear && (start || writeEnable);
    assign shiftS      = (stateR == RUN) && !clear && !terminalS;
    assign lastStepS   = (countS == CW'(STEPS - 1));
    assign dataEnS     = clear || loadS || shiftS;

    // One step of right shift, sign- or zero-filled by the mode latched at start
    always_comb begin
        shiftedS = dataR >> SHIFT;
        if (modeR == MODE_ARITH) begin
            shiftedS = WIDTH'($signed(dataR) >>> SHIFT);
        end else begin
            shiftedS = dataR >> SHIFT;
        end
    end

    // Next register value: abort beats load beats shift
    always_comb begin
        dataNextS = dataR;
        if (clear) begin
            dataNextS = '0;
        end else if (loadS) begin
            dataNextS = dataIn;
        end else if (shiftS) begin
            dataNextS = shiftedS;
        end else begin
            dataNextS = dataR;
        end
    end

    dffe_ref #(.W(WIDTH)) dataReg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (dataEnS),
        .d       (dataNextS),
        .q       (dataR)
    );

    dffe_ref #(.W(1)) modeReg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (runStartS),
        .d       (arith),
        .q       (modeR)
    );

    step_counter #(.STEPS(STEPS), .CW(CW)) stepCount (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear || runStartS),
        .enable   (shiftS),
        .count    (countS),
        .terminal (terminalS)
    );

    // Sequencing FSM; busy/done are registered alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateR <= IDLE;
            busyR  <= 1'b0;
            doneR  <= 1'b0;
        end else if (clear) begin
            stateR <= IDLE;
            busyR  <= 1'b0;
            doneR  <= 1'b0;
        end else begin
            case (stateR)
                IDLE, DONE: begin
                    if (start) begin
                        stateR <= RUN;
                        busyR  <= 1'b1;
                        doneR  <= 1'b0;
                    end else begin
                        stateR <= IDLE;
                        busyR  <= 1'b0;
                        doneR  <= 1'b0;
                    end
                end
                RUN: begin
                    if (lastStepS) begin
                        stateR <= DONE;
                        busyR  <= 1'b0;
                        doneR  <= 1'b1;
                    end else begin
                        stateR <= RUN;
                        busyR  <= 1'b1;
                        doneR  <= 1'b0;
                    end
                end
                default: begin
                    stateR <= IDLE;
                    busyR  <= 1'b0;
                    doneR  <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut = dataR;
    assign count   = countS;
    assign busy    = busyR;
    assign done    = doneR;

endmodule

// File: tb/tb_shift_step_register.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_shift_step_register;

    localparam int WIDTH = 8;
    localparam int SHIFT = 2;
    localparam int STEPS = 3;
    localparam int CW    = $clog2(STEPS + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             writeEnable;
    logic             start;
    logic             arith;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;

    int totalCount = 0;
    int badCount   = 0;

    // Reference model: phase 0=idle, 1=running, 2=done
    int mPhase;
    int mData;
    int mCount;
    bit mArith;

    shift_step_register #(.WIDTH(WIDTH), .SHIFT(SHIFT), .STEPS(STEPS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .writeEnable (writeEnable),
        .start       (start),
        .arith       (arith),
        .dataIn      (dataIn),
        .dataOut     (dataOut),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Divide by 2^SHIFT, rounding toward -inf for signed (arith) interpretation
    function automatic int shiftRef(input int d, input bit a);
        int s;
        int mask;
        mask = (1 << WIDTH) - 1;
        if (a) begin
            s = (d >= (1 << (WIDTH - 1))) ? d - (1 << WIDTH) : d;
            s = s >>> SHIFT;
            return s & mask;
        end else begin
            return d / (1 << SHIFT);
        end
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mData  = 0;
        mCount = 0;
        mArith = 1'b0;
    endtask

    task automatic modelEdge();
        if (clear) begin
            mPhase = 0;
            mData  = 0;
            mCount = 0;
        end else if (mPhase != 1 && start) begin
            mData  = int'(dataIn);
            mArith = arith;
            mCount = 0;
            mPhase = 1;
        end else if (mPhase != 1 && writeEnable) begin
            mData  = int'(dataIn);
            mPhase = 0;
        end else if (mPhase == 1) begin
            mData  = shiftRef(mData, mArith);
            mCount = mCount + 1;
            if (mCount == STEPS) mPhase = 2;
        end else begin
            mPhase = 0;
        end
    endtask

    task automatic checkAll();
        checkVal("dataOut", 64'(dataOut), 64'(mData));
        checkVal("count",   64'(count),   64'(mCount));
        checkVal("busy",    64'(busy),    64'(mPhase == 1));
        checkVal("done",    64'(done),    64'(mPhase == 2));
    endtask

    task automatic drive(input bit s, input bit we, input bit cl, input bit a, input logic [WIDTH-1:0] d);
        start       = s;
        writeEnable = we;
        clear       = cl;
        arith       = a;
        dataIn      = d;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    logic [WIDTH-1:0] arithSeq [4];
    logic [WIDTH-1:0] logicSeq [4];
    logic [WIDTH-1:0] b2bSeq   [4];

    initial begin
        arithSeq = '{8'hB4, 8'hED, 8'hFB, 8'hFE};
        logicSeq = '{8'hB4, 8'h2D, 8'h0B, 8'h02};
        b2bSeq   = '{8'h80, 8'hE0, 8'hF8, 8'hFE};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        modelReset();
        repeat (2) @(negedge clk);
        checkAll();
        checkVal("resetData", 64'(dataOut), 64'h0);
        reset_n = 1'b1;
        step();

        // Arithmetic run with fixed expected sequence
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hB4);
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            checkVal("arithSeq", 64'(dataOut), 64'(arithSeq[i]));
            checkVal("arithCnt", 64'(count), 64'(i));
        end
        checkVal("arithDone", 64'(done), 64'h1);
        step();
        checkVal("doneOnce", 64'(done), 64'h0);

        // Logical run, writeEnable ignored in the second RUN cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hB4);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 1) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            checkVal("logicSeq", 64'(dataOut), 64'(logicSeq[i]));
        end
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkVal("weIdleData", 64'(dataOut), 64'h55);
        checkVal("weIdleCnt",  64'(count),   64'(STEPS));

        // Clear mid-run
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hC3);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkVal("clearData", 64'(dataOut), 64'h0);
        step();
        checkVal("clearNoDone", 64'(done), 64'h0);

        // Asynchronous reset mid-run
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h9A);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkVal("asyncBusy", 64'(busy), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Back-to-back: start held in DONE cycle
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hB4);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) step();
        checkVal("b2bDone", 64'(done), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h80);
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            checkVal("b2bSeq", 64'(dataOut), 64'(b2bSeq[i]));
        end
        step();

        // start and writeEnable together begins a run
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkVal("startWeBusy", 64'(busy), 64'h1);
        repeat (4) step();

        // clear and start together stays idle with zero data
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkVal("clearStart", 64'(dataOut), 64'h0);
        checkVal("clearStartBusy", 64'(busy), 64'h0);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(15) == 0), 1'($urandom_range(1)),
                  WIDTH'($urandom));
            step();
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
